// File: rtl/ts_sync_time_gen.sv
// Local sync-time generator: ns time counter with absolute load, periodic staggered write strobes.
// Optional slewed offset correction is built when TS_SLEW_CORR_EN is defined.
module ts_sync_strobe_ch (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tap,
  input  logic i_en,
  output logic o_wr
);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_wr <= 1'b0;
    else          o_wr <= i_tap & i_en;
  end
endmodule

module ts_sync_time_gen #(
  parameter int TIME_W  = 48,
  parameter int INC_NS  = 8,
  parameter int SLEW_NS = 1,
  parameter int CH_NUM  = 4,
  parameter int STAGGER = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_time_set_wr,
  input  logic [TIME_W-1:0] iv_time_set,
`ifdef TS_SLEW_CORR_EN
  input  logic              i_offset_wr,
  input  logic [31:0]       iv_offset,
  output logic              o_adj_busy,
`endif
  input  logic [31:0]       iv_period_ns,
  input  logic [CH_NUM-1:0] iv_ch_en,
  output logic [TIME_W-1:0] ov_sync_time,
  output logic [CH_NUM-1:0] ov_sync_time_wr
);
  localparam int STAGES = (CH_NUM - 1) * STAGGER;

  logic [TIME_W-1:0] time_q, time_d;

`ifdef TS_SLEW_CORR_EN
  localparam logic signed [31:0] SLEW_S = 32'(SLEW_NS);

  logic signed [31:0] res_q, res_d, step;
  logic               busy_q;

  // step carries the sign of the residual, so res_d = res_q - step in both directions
  always_comb begin
    step  = '0;
    res_d = res_q;
    if (i_time_set_wr)    res_d = '0;
    else if (i_offset_wr) res_d = iv_offset;
    else if (res_q > 0) begin
      step  = (res_q > SLEW_S) ? SLEW_S : res_q;
      res_d = res_q - step;
    end else if (res_q < 0) begin
      step  = (res_q < -SLEW_S) ? -SLEW_S : res_q;
      res_d = res_q - step;
    end
  end

  always_comb begin
    time_d = time_q + TIME_W'(INC_NS) + TIME_W'(step);
    if (i_time_set_wr) time_d = iv_time_set;
  end

  // busy covers the cycle the offset lands and the cycle after the residual drains
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      busy_q <= (res_q != 0) || (res_d != 0);
    end
  end

  assign o_adj_busy = busy_q;
`else
  always_comb begin
    time_d = time_q + TIME_W'(INC_NS);
    if (i_time_set_wr) time_d = iv_time_set;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) time_q <= '0;
    else          time_q <= time_d;
  end

  assign ov_sync_time = time_q;

  // period counter; a load restarts the period and suppresses that cycle's tick
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [32:0] per_sum;
  logic        tick;

  always_comb begin
    per_sum   = {1'b0, per_cnt_q} + 33'(INC_NS);
    tick      = 1'b0;
    per_cnt_d = per_sum[31:0];
    if (i_time_set_wr || (iv_period_ns == '0)) begin
      per_cnt_d = '0;
    end else if (per_sum >= {1'b0, iv_period_ns}) begin
      tick      = 1'b1;
      per_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) per_cnt_q <= '0;
    else          per_cnt_q <= per_cnt_d;
  end

  // vld_pipe[0] is the live tick; higher taps are registered delays
  logic [STAGES:0] vld_pipe;

  generate
    if (STAGES == 0) begin : g_no_pipe
      assign vld_pipe = tick;
    end else begin : g_pipe
      logic [STAGES:1] pipe_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pipe_q <= '0;
        else          pipe_q <= vld_pipe[STAGES-1:0];
      end
      assign vld_pipe = {pipe_q, tick};
    end
  endgenerate

  logic [CH_NUM-1:0] ch_tap;

  always_comb begin
    ch_tap = '0;
    for (int k = 0; k < CH_NUM; k++) ch_tap[k] = vld_pipe[k*STAGGER];
  end

  ts_sync_strobe_ch u_ch [CH_NUM-1:0] (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tap   (ch_tap),
    .i_en    (iv_ch_en),
    .o_wr    (ov_sync_time_wr)
  );
endmodule
